// File: rtl/deaggregator_pkg.sv
// Shared types and sizing for the wide-to-narrow deaggregator.
package deagg_pkg;
   localparam int DATA_W  = 8;
   localparam int FETCH_W = 6;
   localparam int FW_BITS = $clog2(FETCH_W + 1);

   typedef logic [FW_BITS-1:0] fw_t;
   typedef logic [DATA_W-1:0]  lane_t;

   typedef enum logic {EMPTY, DRAIN} deagg_state_e;
endpackage

// File: rtl/deaggregator_if.sv
// Sender (wide FWFT FIFO) and receiver (narrow FIFO) handshake bundle.
// DEAGGREGATOR_LAST_EN adds receiver_last.
interface deaggregator_if #(
   parameter int DATA_WIDTH  = deagg_pkg::DATA_W,
   parameter int FETCH_WIDTH = deagg_pkg::FETCH_W
);
   logic [FETCH_WIDTH*DATA_WIDTH-1:0] sender_data;
   logic                              sender_empty_n;
   logic                              sender_deq;
   logic [DATA_WIDTH-1:0]             receiver_data;
   logic                              receiver_full_n;
   logic                              receiver_enq;
`ifdef DEAGGREGATOR_LAST_EN
   logic                              receiver_last;
`endif

   // master: the deaggregator side
   modport master (
      input  sender_data, sender_empty_n, receiver_full_n,
`ifdef DEAGGREGATOR_LAST_EN
      output receiver_last,
`endif
      output sender_deq, receiver_data, receiver_enq
   );

   modport slave (
      output sender_data, sender_empty_n, receiver_full_n,
`ifdef DEAGGREGATOR_LAST_EN
      input  receiver_last,
`endif
      input  sender_deq, receiver_data, receiver_enq
   );
endinterface

// File: rtl/deaggregator_fw_ctrl.sv
// Runtime fetch-width register; illegal widths (0 or above FETCH_WIDTH) are dropped.
module deagg_fw_ctrl #(
   parameter int FETCH_WIDTH = deagg_pkg::FETCH_W,
   localparam int FWB        = $clog2(FETCH_WIDTH + 1)
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           change_fetch_width,
   input  logic [FWB-1:0] input_fetch_width,
   output logic [FWB-1:0] cur_fw
);
   logic legal;

   assign legal = (input_fetch_width != '0) && (input_fetch_width <= FWB'(FETCH_WIDTH));

   always_ff @(posedge clk) begin
      if (rst)                              cur_fw <= FWB'(FETCH_WIDTH);
      else if (change_fetch_width && legal) cur_fw <= input_fetch_width;
   end
endmodule

// File: rtl/deaggregator.sv
// Pops one wide word from an FWFT FIFO and streams its low cur_fw lanes, lane 0 first.
// DEAGGREGATOR_LAST_EN adds receiver_last on the final lane of each word.
module deaggregator
   import deagg_pkg::*;
#(
   parameter int DATA_WIDTH  = DATA_W,
   parameter int FETCH_WIDTH = FETCH_W,
   localparam int FWB        = $clog2(FETCH_WIDTH + 1),
   localparam int IW         = (FETCH_WIDTH > 1) ? $clog2(FETCH_WIDTH) : 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  change_fetch_width,
   input  logic [FWB-1:0]        input_fetch_width,
   deaggregator_if.master        bus
);
   logic [FETCH_WIDTH-1:0][DATA_WIDTH-1:0] word_q, word_d;
   logic [IW-1:0]   idx_q, idx_d;
   logic [FWB-1:0]  rem_q, rem_d;
   logic [FWB-1:0]  word_fw_q, word_fw_d;
   logic [FWB-1:0]  cur_fw;
   deagg_state_e    state_q, state_d;
   logic            rst_q;
   logic            enq, deq;

   deagg_fw_ctrl #(.FETCH_WIDTH(FETCH_WIDTH)) u_fw_ctrl (
      .clk                (clk),
      .rst                (rst),
      .change_fetch_width (change_fetch_width),
      .input_fetch_width  (input_fetch_width),
      .cur_fw             (cur_fw)
   );

   // rst_q keeps the sender untouched for one cycle after reset releases
   assign enq = !rst && (state_q == DRAIN) && bus.receiver_full_n;
   assign deq = !rst && !rst_q && bus.sender_empty_n &&
                ((state_q == EMPTY) || ((rem_q == FWB'(1)) && enq));

   assign bus.receiver_enq  = enq;
   assign bus.sender_deq    = deq;
   assign bus.receiver_data = word_q[idx_q];
`ifdef DEAGGREGATOR_LAST_EN
   assign bus.receiver_last = enq && (rem_q == FWB'(1));
`endif

   always_comb begin
      word_d    = word_q;
      idx_d     = idx_q;
      rem_d     = rem_q;
      word_fw_d = word_fw_q;
      state_d   = state_q;
      if (deq) begin
         // the popped word takes the width in force before any same-cycle change
         word_d    = bus.sender_data;
         idx_d     = '0;
         rem_d     = cur_fw;
         word_fw_d = cur_fw;
         state_d   = DRAIN;
      end else if (enq) begin
         idx_d   = idx_q + IW'(1);
         rem_d   = rem_q - FWB'(1);
         state_d = (rem_q == FWB'(1)) ? EMPTY : DRAIN;
      end
   end

   always_ff @(posedge clk) begin
      rst_q <= rst;
      if (rst) begin
         word_q    <= '0;
         idx_q     <= '0;
         rem_q     <= '0;
         word_fw_q <= FWB'(FETCH_WIDTH);
         state_q   <= EMPTY;
      end else begin
         word_q    <= word_d;
         idx_q     <= idx_d;
         rem_q     <= rem_d;
         word_fw_q <= word_fw_d;
         state_q   <= state_d;
      end
   end

   idx_in_word: assert property (@(posedge clk) disable iff (rst)
      (state_q == DRAIN) |-> (FWB'(idx_q) < word_fw_q));
endmodule

// File: tb/tb_deaggregator.sv
// Randomized bench for deaggregator against a lane-queue reference model.
module tb_deaggregator;
   import deagg_pkg::*;

   logic clk = 0;
   logic rst = 1;
   logic chg = 0;
   fw_t  fw_in = '0;
   always #5 clk = ~clk;

   deaggregator_if #(.DATA_WIDTH(8), .FETCH_WIDTH(6)) bus();

   deaggregator dut (
      .clk                (clk),
      .rst                (rst),
      .change_fetch_width (chg),
      .input_fetch_width  (fw_in),
      .bus                (bus)
   );

   int n_cmp = 0;
   int n_err = 0;

   // model state: sender FIFO contents, lanes still owed, config width
   logic [47:0] fifo[$];
   lane_t       pend[$];
   int          cur_fw = 6;
   bit          blk = 1;
   bit          full_n = 1;
   int          cyc = 0;

   lane_t out_log[$];
   int    enq_cyc[$];
   int    deq_cyc[$];
   int    n_last = 0;

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   task automatic step();
      logic  e_enq, e_deq;
      logic [47:0] w;
      bus.sender_empty_n  = (fifo.size() > 0);
      bus.sender_data     = (fifo.size() > 0) ? fifo[0] : 48'h0;
      bus.receiver_full_n = full_n;
      @(negedge clk);
      e_enq = !rst && (pend.size() > 0) && full_n;
      e_deq = !rst && !blk && (fifo.size() > 0) &&
              ((pend.size() == 0) || ((pend.size() == 1) && e_enq));
      chk("deq", bus.sender_deq, e_deq);
      chk("enq", bus.receiver_enq, e_enq);
      if (e_enq) chk("data", bus.receiver_data, pend[0]);
`ifdef DEAGGREGATOR_LAST_EN
      chk("last", bus.receiver_last, e_enq && (pend.size() == 1));
      if (bus.receiver_last) n_last++;
`endif
      if (bus.receiver_enq) begin
         out_log.push_back(bus.receiver_data);
         enq_cyc.push_back(cyc);
      end
      if (bus.sender_deq) deq_cyc.push_back(cyc);
      @(posedge clk);
      cyc++;
      if (rst) begin
         pend.delete();
         cur_fw = 6;
         blk = 1;
      end else begin
         if (e_enq) void'(pend.pop_front());
         if (e_deq) begin
            w = fifo.pop_front();
            for (int i = 0; i < cur_fw; i++) pend.push_back(w[i*8 +: 8]);
         end
         if (chg && fw_in >= 1 && fw_in <= 6) cur_fw = int'(fw_in);
         blk = 0;
      end
      #1;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   function automatic logic [47:0] mkword(input int base);
      logic [47:0] w;
      for (int i = 0; i < 6; i++) w[i*8 +: 8] = 8'(base + i);
      return w;
   endfunction

   task automatic clr();
      out_log.delete(); enq_cyc.delete(); deq_cyc.delete(); n_last = 0;
   endtask

   task automatic chk_seq(input string tag, input int base, input int cnt);
      chk({tag, "_len"}, out_log.size(), cnt);
      for (int i = 0; i < cnt && i < out_log.size(); i++) chk(tag, out_log[i], 8'(base + i));
   endtask

   task automatic set_fw(input int w);
      chg = 1; fw_in = fw_t'(w);
      step();
      chg = 0;
   endtask

   initial begin
      logic [47:0] words[$];
      int k, b;
      bus.sender_data = '0; bus.sender_empty_n = 0; bus.receiver_full_n = 1;
      #1;
      // reset state
      run(3);
      chk("rst_enq", bus.receiver_enq, 0);
      chk("rst_deq", bus.sender_deq, 0);
      rst = 0;

      // single word, full width
      clr(); fifo.push_back(mkword(0));
      run(10);
      chk_seq("t1", 0, 6);
      chk("t1_ndeq", deq_cyc.size(), 1);

      // two words back to back
      clr(); fifo.push_back(mkword(0)); fifo.push_back(mkword(6));
      run(16);
      chk_seq("t2", 0, 12);
      if (enq_cyc.size() == 12 && deq_cyc.size() == 2) begin
         chk("t2_gapless", enq_cyc[11] - enq_cyc[0], 11);
         chk("t2_deq0", deq_cyc[0], enq_cyc[0] - 1);
         chk("t2_deq1", deq_cyc[1], enq_cyc[5]);
      end else chk("t2_counts", {enq_cyc.size(), deq_cyc.size()}, {32'd12, 32'd2});

      // narrow width set while idle
      set_fw(2);
      clr(); fifo.push_back(mkword(10)); fifo.push_back(mkword(20));
      run(10);
      chk("t3_len", out_log.size(), 4);
      if (out_log.size() == 4) begin
         chk("t3_a", out_log[0], 10); chk("t3_b", out_log[1], 11);
         chk("t3_c", out_log[2], 20); chk("t3_d", out_log[3], 21);
      end

      // width change mid-word applies to the next word only
      set_fw(6);
      clr(); fifo.push_back(mkword(30)); fifo.push_back(mkword(36));
      run(3);
      set_fw(4);
      run(15);
      chk_seq("t4", 30, 10);
      set_fw(6);

      // random stalls over 20 random words
      clr(); words.delete();
      for (int i = 0; i < 20; i++) begin
         words.push_back({$urandom, $urandom} & 48'hFFFF_FFFF_FFFF);
         fifo.push_back(words[i]);
      end
      k = 0;
      while ((fifo.size() > 0 || pend.size() > 0) && k < 2000) begin
         full_n = $urandom_range(0, 1);
         step();
         k++;
      end
      full_n = 1;
      chk("t5_done", k < 2000, 1);
      chk("t5_len", out_log.size(), 120);
      for (int i = 0; i < 120 && i < out_log.size(); i++)
         chk("t5_data", out_log[i], words[i/6][(i%6)*8 +: 8]);

      // reset mid-word discards the word in flight
      clr(); fifo.push_back(mkword(50)); fifo.push_back(mkword(60));
      k = 0;
      while (out_log.size() < 3 && k < 50) begin step(); k++; end
      chk("t6_wait", out_log.size(), 3);
      rst = 1; step(); rst = 0;
      chk("t6_rst_enq", bus.receiver_enq, 0);
      clr();
      run(12);
      chk_seq("t6", 60, 6);
      set_fw(0);
      set_fw(7);
      clr(); fifo.push_back(mkword(70));
      run(10);
      chk_seq("t6_ill", 70, 6);
`ifdef DEAGGREGATOR_LAST_EN
      chk("t6_nlast", n_last, 1);
`endif

      // random widths with random stalls
      clr(); words.delete(); b = 0;
      for (int i = 0; i < 30; i++) begin
         if ($urandom_range(0, 3) == 0) begin
            chg = 1; fw_in = fw_t'($urandom_range(0, 7));
         end
         if ($urandom_range(0, 1) == 1) fifo.push_back(mkword(8 * i));
         full_n = ($urandom_range(0, 3) != 0);
         step();
         chg = 0;
      end
      full_n = 1;
      run(60);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
